// File: rtl/carrier_loop_pkg.sv
// ----------------------------------------------------------------------------
// carrier_loop_pkg
// Shared definitions for the Costas carrier-loop filter:
//   - FSM state encoding
//   - default widths, loop coefficients and FCW nominal/limit values
//   - sat_clamp: symmetric saturating clamp on a 64-bit signed value
// ----------------------------------------------------------------------------
package carrier_loop_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ACC  = 3'd2,
        S_SUM  = 3'd3,
        S_OUT  = 3'd4
    } clf_state_t;

    localparam int CLF_ERR_WIDTH  = 13;
    localparam int CLF_COEF_WIDTH = 16;
    localparam int CLF_COEF_FRAC  = 16;
    localparam int CLF_ACC_WIDTH  = 40;
    localparam int CLF_NCO_WIDTH  = 32;

    localparam logic signed [CLF_COEF_WIDTH-1:0] CLF_C1 = 16'sd1200;
    localparam logic signed [CLF_COEF_WIDTH-1:0] CLF_C2 = 16'sd40;

    // 10 MHz nominal carrier at a 100 MHz clock, +/-100 kHz pull range.
    localparam logic [CLF_NCO_WIDTH-1:0] CLF_FCW_INIT  = 32'd429496730;
    localparam logic [CLF_NCO_WIDTH-1:0] CLF_FCW_LIMIT = 32'd4294967;

    // Clamp v into [-lim, +lim]; lim is expected to be non-negative.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] v,
        input logic signed [63:0] lim
    );
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage

// File: rtl/carrier_loop_if.sv
// ----------------------------------------------------------------------------
// carrier_loop_if
// Phase-detector -> loop-filter -> NCO signal bundle.
//   iw_Loop_Filter_ReWork_h : re-initialise pulse
//   iw_Carr_Error_Rdy_h     : phase error valid strobe
//   iw_Carr_Phase_Error     : signed 2QN phase error
//   ow_Carr_Fcw             : NCO frequency control word
//   ow_Carr_Fcw_Valid_h     : FCW update strobe
//   ow_Carr_Err_Overrun_h   : sticky dropped-error flag
// master = upstream driver, slave = loop filter.
// ----------------------------------------------------------------------------
interface carrier_loop_if #(
    parameter int ERR_WIDTH = 13,
    parameter int NCO_WIDTH = 32
);
    logic                        iw_Loop_Filter_ReWork_h;
    logic                        iw_Carr_Error_Rdy_h;
    logic signed [ERR_WIDTH-1:0] iw_Carr_Phase_Error;
    logic        [NCO_WIDTH-1:0] ow_Carr_Fcw;
    logic                        ow_Carr_Fcw_Valid_h;
    logic                        ow_Carr_Err_Overrun_h;

    modport master (
        output iw_Loop_Filter_ReWork_h, iw_Carr_Error_Rdy_h, iw_Carr_Phase_Error,
        input  ow_Carr_Fcw, ow_Carr_Fcw_Valid_h, ow_Carr_Err_Overrun_h
    );

    modport slave (
        input  iw_Loop_Filter_ReWork_h, iw_Carr_Error_Rdy_h, iw_Carr_Phase_Error,
        output ow_Carr_Fcw, ow_Carr_Fcw_Valid_h, ow_Carr_Err_Overrun_h
    );
endinterface

// File: rtl/carrier_loop_filter_sat.sv
// ----------------------------------------------------------------------------
// sat_clamp_signed
// Combinational symmetric saturation: o_val = clamp(i_val, -i_lim, +i_lim).
//   i_val : signed input, W bits
//   i_lim : non-negative limit, W bits
//   o_val : clamped result, W bits
// W must be below 64.
// ----------------------------------------------------------------------------
module sat_clamp_signed
    import carrier_loop_pkg::*;
#(
    parameter int W = 41
) (
    input  logic signed [W-1:0] i_val,
    input  logic signed [W-1:0] i_lim,
    output logic signed [W-1:0] o_val
);
    localparam int PAD = 64 - W;

    logic signed [63:0] w_val_ext;
    logic signed [63:0] w_lim_ext;

    assign w_val_ext = {{PAD{i_val[W-1]}}, i_val};
    assign w_lim_ext = {{PAD{i_lim[W-1]}}, i_lim};
    // Result is within +/-i_lim, so narrowing back to W bits is lossless.
    assign o_val     = W'(sat_clamp(w_val_ext, w_lim_ext));
endmodule

// File: rtl/carrier_loop_filter.sv
// ----------------------------------------------------------------------------
// carrier_loop_filter
// Second-order (P + I) carrier loop filter. Each accepted phase error runs
// through a five-state sequence IDLE -> MUL -> ACC -> SUM -> OUT and yields
// one FCW update (valid in the 4th cycle after the strobe).
//   iw_Clk_p_g : system clock, rising edge
//   iw_Rst_n_g : asynchronous active-low reset
//   lp         : carrier_loop_if slave (error in, FCW out, status)
// ----------------------------------------------------------------------------
module carrier_loop_filter
    import carrier_loop_pkg::*;
#(
    parameter int                             ERR_WIDTH  = CLF_ERR_WIDTH,
    parameter int                             COEF_WIDTH = CLF_COEF_WIDTH,
    parameter logic signed [COEF_WIDTH-1:0]   C1         = CLF_C1,
    parameter logic signed [COEF_WIDTH-1:0]   C2         = CLF_C2,
    parameter int                             COEF_FRAC  = CLF_COEF_FRAC,
    parameter int                             ACC_WIDTH  = CLF_ACC_WIDTH,
    parameter int                             NCO_WIDTH  = CLF_NCO_WIDTH,
    parameter logic [NCO_WIDTH-1:0]           FCW_INIT   = CLF_FCW_INIT,
    parameter logic [NCO_WIDTH-1:0]           FCW_LIMIT  = CLF_FCW_LIMIT
) (
    input  logic           iw_Clk_p_g,
    input  logic           iw_Rst_n_g,
    carrier_loop_if.slave  lp
);
    // One guard bit above the accumulator so no sum can wrap before clamping.
    localparam int AW1 = ACC_WIDTH + 1;

    localparam logic signed [AW1-1:0] OFF_LIM =
        $signed({{(AW1-NCO_WIDTH){1'b0}}, FCW_LIMIT});
    // Anti-windup bound: the integrator alone may never exceed the FCW range.
    localparam logic signed [AW1-1:0] INT_LIM = OFF_LIM <<< COEF_FRAC;

    clf_state_t                  r_state;
    logic signed [ERR_WIDTH-1:0] r_err;
    logic signed [ACC_WIDTH-1:0] r_p;
    logic signed [ACC_WIDTH-1:0] r_i;
    logic signed [ACC_WIDTH-1:0] r_integ;
    logic        [NCO_WIDTH-1:0] r_fcw;
    logic                        r_valid;
    logic                        r_ovr;

    logic signed [ACC_WIDTH-1:0] w_err_ext;
    logic signed [ACC_WIDTH-1:0] w_c1_ext;
    logic signed [ACC_WIDTH-1:0] w_c2_ext;
    logic signed [AW1-1:0]       w_isum;
    logic signed [AW1-1:0]       w_iclamp;
    logic signed [AW1-1:0]       w_osum;
    logic signed [AW1-1:0]       w_oshift;
    logic signed [AW1-1:0]       w_off;
    logic                        w_stb;
    logic                        w_rework;

    assign w_stb    = lp.iw_Carr_Error_Rdy_h;
    assign w_rework = lp.iw_Loop_Filter_ReWork_h;

    assign w_err_ext = {{(ACC_WIDTH-ERR_WIDTH){r_err[ERR_WIDTH-1]}}, r_err};
    assign w_c1_ext  = {{(ACC_WIDTH-COEF_WIDTH){C1[COEF_WIDTH-1]}}, C1};
    assign w_c2_ext  = {{(ACC_WIDTH-COEF_WIDTH){C2[COEF_WIDTH-1]}}, C2};

    assign w_isum   = {r_integ[ACC_WIDTH-1], r_integ} + {r_i[ACC_WIDTH-1], r_i};
    assign w_osum   = {r_integ[ACC_WIDTH-1], r_integ} + {r_p[ACC_WIDTH-1], r_p};
    // Arithmetic shift: floor rounding toward -inf.
    assign w_oshift = w_osum >>> COEF_FRAC;

    sat_clamp_signed #(.W(AW1)) u_int_clamp (
        .i_val (w_isum),
        .i_lim (INT_LIM),
        .o_val (w_iclamp)
    );

    sat_clamp_signed #(.W(AW1)) u_off_clamp (
        .i_val (w_oshift),
        .i_lim (OFF_LIM),
        .o_val (w_off)
    );

    always_ff @(posedge iw_Clk_p_g or negedge iw_Rst_n_g) begin
        if (!iw_Rst_n_g) begin
            r_state <= S_IDLE;
            r_err   <= '0;
            r_p     <= '0;
            r_i     <= '0;
            r_integ <= '0;
            r_fcw   <= FCW_INIT;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rework) begin
                // Overrides everything, including a same-cycle strobe and
                // any computation in flight.
                r_state <= S_IDLE;
                r_integ <= '0;
                r_fcw   <= FCW_INIT;
                r_ovr   <= 1'b0;
            end else begin
                if (w_stb && (r_state != S_IDLE))
                    r_ovr <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (w_stb) begin
                            r_err   <= lp.iw_Carr_Phase_Error;
                            r_state <= S_MUL;
                        end
                    end
                    S_MUL: begin
                        r_p     <= w_err_ext * w_c1_ext;
                        r_i     <= w_err_ext * w_c2_ext;
                        r_state <= S_ACC;
                    end
                    S_ACC: begin
                        r_integ <= ACC_WIDTH'(w_iclamp);
                        r_state <= S_SUM;
                    end
                    S_SUM: begin
                        // Offset is bounded by FCW_LIMIT, so this never wraps.
                        r_fcw   <= FCW_INIT + NCO_WIDTH'(w_off);
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                    S_OUT: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign lp.ow_Carr_Fcw           = r_fcw;
    assign lp.ow_Carr_Fcw_Valid_h   = r_valid;
    assign lp.ow_Carr_Err_Overrun_h = r_ovr;

endmodule

// File: tb/tb_carrier_loop_filter.sv
// ----------------------------------------------------------------------------
// tb_carrier_loop_filter
// Two filter instances (default coefficients, and C1=0/C2=32767/limit=100)
// driven by the same stimulus. A reference model predicts each FCW update
// into a per-instance queue; a monitor compares on every valid strobe, and
// checks FCW hold and the overrun flag every cycle.
// ----------------------------------------------------------------------------
module tb_carrier_loop_filter;

    localparam longint INIT = 429496730;

    typedef struct {
        longint fcw;
        int     due;
    } exp_t;

    logic clk;
    logic rst_n;

    carrier_loop_if #(.ERR_WIDTH(13), .NCO_WIDTH(32)) if0 ();
    carrier_loop_if #(.ERR_WIDTH(13), .NCO_WIDTH(32)) if1 ();

    carrier_loop_filter dut0 (
        .iw_Clk_p_g (clk),
        .iw_Rst_n_g (rst_n),
        .lp         (if0)
    );

    carrier_loop_filter #(
        .C1        (16'sd0),
        .C2        (16'sd32767),
        .FCW_LIMIT (32'd100)
    ) dut1 (
        .iw_Clk_p_g (clk),
        .iw_Rst_n_g (rst_n),
        .lp         (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int     n_chk  = 0;
    int     n_fail = 0;

    // Reference model state
    longint m_c1 [2] = '{1200, 0};
    longint m_c2 [2] = '{40, 32767};
    longint m_lim[2] = '{4294967, 100};
    longint m_integ[2] = '{0, 0};
    longint cur_fcw[2] = '{INIT, INIT};
    bit     ovr_exp = 1'b0;
    int     last_acc = -100;
    exp_t   q0[$];
    exp_t   q1[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic longint clampl(input longint v, input longint lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // floor(v / 2^16) with plain integer division
    function automatic longint floor_div16(input longint v);
        longint q;
        q = v / 65536;
        if ((v < 0) && ((v % 65536) != 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint model(input int d, input longint err);
        longint p, i, off;
        p = err * m_c1[d];
        i = err * m_c2[d];
        m_integ[d] = clampl(m_integ[d] + i, m_lim[d] * 65536);
        off = clampl(floor_div16(m_integ[d] + p), m_lim[d]);
        return INIT + off;
    endfunction

    // Drive one cycle of inputs (entered at a negedge) and update the model.
    task automatic tick(input bit rw, input bit stb, input int err);
        int   e;
        exp_t x;
        e = edge_n + 1;
        if0.iw_Loop_Filter_ReWork_h = rw;
        if1.iw_Loop_Filter_ReWork_h = rw;
        if0.iw_Carr_Error_Rdy_h     = stb;
        if1.iw_Carr_Error_Rdy_h     = stb;
        if0.iw_Carr_Phase_Error     = 13'(err);
        if1.iw_Carr_Phase_Error     = 13'(err);
        if (rw) begin
            m_integ[0] = 0;
            m_integ[1] = 0;
            cur_fcw[0] = INIT;
            cur_fcw[1] = INIT;
            ovr_exp    = 1'b0;
            while (q0.size() > 0 && q0[$].due >= e) void'(q0.pop_back());
            while (q1.size() > 0 && q1[$].due >= e) void'(q1.pop_back());
            last_acc = e - 4;
        end else if (stb) begin
            if (e - last_acc >= 5) begin
                last_acc = e;
                x.due = e + 3;
                x.fcw = model(0, err);
                q0.push_back(x);
                x.fcw = model(1, err);
                q1.push_back(x);
            end else begin
                ovr_exp = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 0);
    endtask

    task automatic mon(input int d, input logic v, input logic [31:0] f, input logic o);
        exp_t x;
        bit   have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0 && (v || q0[0].due < edge_n)) begin
            x = q0.pop_front(); have = 1'b1;
        end else if (d == 1 && q1.size() > 0 && (v || q1[0].due < edge_n)) begin
            x = q1.pop_front(); have = 1'b1;
        end
        if (have && !v) begin
            chk($sformatf("dut%0d missing valid", d), 0, 1);
        end else if (v && !have) begin
            chk($sformatf("dut%0d unexpected valid", d), 1, 0);
        end else if (v && have) begin
            chk($sformatf("dut%0d valid latency", d), edge_n, x.due);
            cur_fcw[d] = x.fcw;
        end
        chk($sformatf("dut%0d fcw", d), f, cur_fcw[d]);
        chk($sformatf("dut%0d overrun", d), o, ovr_exp);
    endtask

    initial begin
        wait (rst_n === 1'b1);
        forever begin
            @(posedge clk);
            #1;
            mon(0, if0.ow_Carr_Fcw_Valid_h, if0.ow_Carr_Fcw, if0.ow_Carr_Err_Overrun_h);
            mon(1, if1.ow_Carr_Fcw_Valid_h, if1.ow_Carr_Fcw, if1.ow_Carr_Err_Overrun_h);
        end
    end

    initial begin
        rst_n = 1'b0;
        if0.iw_Loop_Filter_ReWork_h = 1'b0; if1.iw_Loop_Filter_ReWork_h = 1'b0;
        if0.iw_Carr_Error_Rdy_h     = 1'b0; if1.iw_Carr_Error_Rdy_h     = 1'b0;
        if0.iw_Carr_Phase_Error     = '0;   if1.iw_Carr_Phase_Error     = '0;
        repeat (3) @(negedge clk);
        chk("reset fcw",     if0.ow_Carr_Fcw, INIT);
        chk("reset valid",   if0.ow_Carr_Fcw_Valid_h, 0);
        chk("reset overrun", if0.ow_Carr_Err_Overrun_h, 0);
        chk("reset fcw1",    if1.ow_Carr_Fcw, INIT);
        rst_n = 1'b1;
        @(negedge clk);

        // +1024 from a clean state
        tick(1'b0, 1'b1, 1024); idle(6);
        chk("pos1024 fcw", if0.ow_Carr_Fcw, 429496749);
        chk("pos1024 fcw1", if1.ow_Carr_Fcw, INIT + 100);

        // -1024 from a clean state: floor rounding
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, -1024); idle(6);
        chk("neg1024 fcw", if0.ow_Carr_Fcw, 429496710);

        // Strobes two cycles apart: second dropped, overrun set
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 1024); idle(1);
        tick(1'b0, 1'b1, 512);  idle(6);
        chk("overrun set", if0.ow_Carr_Err_Overrun_h, 1);
        chk("overrun drop fcw", if0.ow_Carr_Fcw, 429496749);
        tick(1'b1, 1'b0, 0); idle(1);
        chk("rework overrun", if0.ow_Carr_Err_Overrun_h, 0);
        chk("rework fcw", if0.ow_Carr_Fcw, INIT);
        tick(1'b0, 1'b1, 1024); idle(6);
        chk("after rework fcw", if0.ow_Carr_Fcw, 429496749);

        // Anti-windup on the high-gain instance
        tick(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 4095); idle(4);
            chk("windup hi fcw1", if1.ow_Carr_Fcw, INIT + 100);
        end
        tick(1'b0, 1'b1, -4095); idle(6);
        chk("windup lo fcw1", if1.ow_Carr_Fcw, INIT - 100);

        // ReWork with a same-cycle strobe, and during S_ACC
        tick(1'b1, 1'b1, 2000); idle(6);
        chk("rework+stb fcw", if0.ow_Carr_Fcw, INIT);
        tick(1'b0, 1'b1, 1024); idle(1);
        tick(1'b1, 1'b0, 0);    idle(6);
        chk("rework in acc fcw", if0.ow_Carr_Fcw, INIT);
        tick(1'b0, 1'b1, 1024); idle(6);
        chk("rework in acc integ", if0.ow_Carr_Fcw, 429496749);

        // Most-negative code
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, -4096); idle(6);

        // Randomised traffic with occasional re-work and overruns
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(15) == 0)
                tick(1'b1, $urandom_range(1) == 1, 0);
            else
                tick(1'b0, 1'b1, int'($urandom_range(8191)) - 4096);
            idle($urandom_range(7));
        end
        idle(8);
        chk("queue0 drained", q0.size(), 0);
        chk("queue1 drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
